// File: rtl/ddr3_prbs_tester.sv
// PRBS traffic generator/checker for the user side of the DDR3 controller.
// Writes a 16-bit Galois LFSR stream, reads it back and scores mismatches.
module ddr3_prbs_tester #(
    parameter logic [27:0] DATA_MAX   = 28'd5120,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          RD_LATENCY = 1,
    parameter int          GAP_CYCLES = 256,
    parameter bit          LOOP       = 1'b1
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        ddr3_init_done,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        error_flag,
    output logic [15:0] err_cnt,
    output logic [27:0] first_err_addr,
    output logic [15:0] pass_cnt,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN, NEXT, STOP} state_e;

    localparam logic [15:0] SEED_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [27:0] LAST_ADDR  = DATA_MAX - 28'd1;
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [2:0]  DRAIN_LAST = 3'(RD_LATENCY - 1);

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_e      state_q;
    logic [15:0] lfsr_q, seed_q, wr_data_q, pass_cnt_q;
    logic [27:0] addr_q;
    logic [31:0] gap_cnt_q;
    logic [2:0]  drain_cnt_q;
    logic        wr_en_q, rd_en_q, done_q;

    logic [15:0] lfsr_d, seed_d;
    logic        abort;

    assign lfsr_d = lfsr_step(lfsr_q);
    assign seed_d = (lfsr_d == 16'h0000) ? 16'h0001 : lfsr_d;
    // Losing calibration mid-pass discards the pass; IDLE and STOP are already quiescent.
    assign abort  = !ddr3_init_done && (state_q != IDLE) && (state_q != STOP);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED_INIT;
            seed_q      <= SEED_INIT;
            addr_q      <= '0;
            gap_cnt_q   <= '0;
            drain_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
            pass_cnt_q  <= '0;
        end else if (abort) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ddr3_init_done) begin
                        state_q   <= WRITE;
                        lfsr_q    <= seed_q;
                        addr_q    <= '0;
                        wr_en_q   <= 1'b1;
                        wr_data_q <= seed_q;
                    end
                end
                WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q   <= GAP;
                        wr_en_q   <= 1'b0;
                        gap_cnt_q <= '0;
                    end else begin
                        lfsr_q    <= lfsr_d;
                        wr_data_q <= lfsr_d;
                        addr_q    <= addr_q + 28'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= READ;
                        lfsr_q  <= seed_q;
                        addr_q  <= '0;
                        rd_en_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 32'd1;
                    end
                end
                READ: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q     <= DRAIN;
                        rd_en_q     <= 1'b0;
                        drain_cnt_q <= '0;
                    end else begin
                        lfsr_q <= lfsr_d;
                        addr_q <= addr_q + 28'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) state_q <= NEXT;
                    else drain_cnt_q <= drain_cnt_q + 3'd1;
                end
                NEXT: begin
                    // lfsr_q still holds the last compared word, so the next seed continues the stream.
                    pass_cnt_q <= pass_cnt_q + 16'd1;
                    seed_q     <= seed_d;
                    if (LOOP) begin
                        state_q   <= WRITE;
                        lfsr_q    <= seed_d;
                        addr_q    <= '0;
                        wr_en_q   <= 1'b1;
                        wr_data_q <= seed_d;
                    end else begin
                        state_q <= STOP;
                        done_q  <= 1'b1;
                    end
                end
                STOP: state_q <= STOP;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Compare pipeline: {valid, expected, addr} travels alongside the read latency.
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [15:0]           pipe_exp_q  [RD_LATENCY];
    logic [27:0]           pipe_addr_q [RD_LATENCY];
    logic                  error_flag_q;
    logic [15:0]           err_cnt_q;
    logic [27:0]           first_err_addr_q;
    logic                  mismatch;

    assign mismatch = pipe_vld_q[RD_LATENCY-1] && (rd_data != pipe_exp_q[RD_LATENCY-1]);

    // NOTE: only the valid bits get a reset; payload stages are always qualified by them.
    always_ff @(posedge clk_50m) begin
        pipe_exp_q[0]  <= lfsr_q;
        pipe_addr_q[0] <= addr_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_exp_q[i]  <= pipe_exp_q[i-1];
            pipe_addr_q[i] <= pipe_addr_q[i-1];
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            pipe_vld_q       <= '0;
            error_flag_q     <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
        end else if (abort) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= rd_en_q;
            for (int i = 1; i < RD_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
            if (mismatch) begin
                error_flag_q <= 1'b1;
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                if (!error_flag_q) first_err_addr_q <= pipe_addr_q[RD_LATENCY-1];
            end
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_data        = wr_data_q;
    assign rd_en          = rd_en_q;
    assign error_flag     = error_flag_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_addr_q;
    assign pass_cnt       = pass_cnt_q;
    assign done           = done_q;

endmodule

// File: tb/tb_ddr3_prbs_tester.sv
// Directed bench: three tester instances against a loopback memory model with
// per-instance read latency and optional single-word corruption.
module tb_ddr3_prbs_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  init_v = '0;
    logic [2:0]  wr_en_v, rd_en_v, flag_v, done_v;
    logic [15:0] wr_data_v [3];
    logic [15:0] rd_data_v [3];
    logic [15:0] err_v     [3];
    logic [15:0] pass_v    [3];
    logic [27:0] first_v   [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // dut 0: loopback main path; dut 1: single pass, zero seed; dut 2: latency 3, gap 1
    ddr3_prbs_tester #(.DATA_MAX(28'd8), .SEED(16'hACE1), .RD_LATENCY(1), .GAP_CYCLES(4), .LOOP(1'b1)) dut_a (
        .clk_50m(clk), .rst(rst), .ddr3_init_done(init_v[0]),
        .wr_en(wr_en_v[0]), .wr_data(wr_data_v[0]), .rd_en(rd_en_v[0]), .rd_data(rd_data_v[0]),
        .error_flag(flag_v[0]), .err_cnt(err_v[0]), .first_err_addr(first_v[0]),
        .pass_cnt(pass_v[0]), .done(done_v[0]));

    ddr3_prbs_tester #(.DATA_MAX(28'd4), .SEED(16'h0000), .RD_LATENCY(1), .GAP_CYCLES(2), .LOOP(1'b0)) dut_b (
        .clk_50m(clk), .rst(rst), .ddr3_init_done(init_v[1]),
        .wr_en(wr_en_v[1]), .wr_data(wr_data_v[1]), .rd_en(rd_en_v[1]), .rd_data(rd_data_v[1]),
        .error_flag(flag_v[1]), .err_cnt(err_v[1]), .first_err_addr(first_v[1]),
        .pass_cnt(pass_v[1]), .done(done_v[1]));

    ddr3_prbs_tester #(.DATA_MAX(28'd8), .SEED(16'hACE1), .RD_LATENCY(3), .GAP_CYCLES(1), .LOOP(1'b1)) dut_c (
        .clk_50m(clk), .rst(rst), .ddr3_init_done(init_v[2]),
        .wr_en(wr_en_v[2]), .wr_data(wr_data_v[2]), .rd_en(rd_en_v[2]), .rd_data(rd_data_v[2]),
        .error_flag(flag_v[2]), .err_cnt(err_v[2]), .first_err_addr(first_v[2]),
        .pass_cnt(pass_v[2]), .done(done_v[2]));

    // Loopback memory: a strobe burst always starts at address 0.
    logic [15:0] mem [3][16];
    logic [15:0] rdq [3][4];
    int wr_ptr [3], rd_ptr [3], wr_cnt [3], rd_cnt [3];
    int corrupt [3] = '{-1, -1, -1};
    int overlap;

    function automatic int lat_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            overlap <= 0;
            for (int d = 0; d < 3; d++) begin
                wr_ptr[d] <= 0; rd_ptr[d] <= 0; wr_cnt[d] <= 0; rd_cnt[d] <= 0;
                for (int k = 0; k < 4; k++) rdq[d][k] <= 16'hDEAD;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (wr_en_v[d]) begin
                    mem[d][wr_ptr[d] % 16] <= wr_data_v[d];
                    wr_ptr[d] <= wr_ptr[d] + 1;
                    wr_cnt[d] <= wr_cnt[d] + 1;
                end else begin
                    wr_ptr[d] <= 0;
                end
                if (rd_en_v[d]) begin
                    rdq[d][0] <= mem[d][rd_ptr[d] % 16] ^ ((rd_ptr[d] == corrupt[d]) ? 16'h0001 : 16'h0000);
                    rd_ptr[d] <= rd_ptr[d] + 1;
                    rd_cnt[d] <= rd_cnt[d] + 1;
                end else begin
                    rdq[d][0] <= 16'hDEAD;
                    rd_ptr[d] <= 0;
                end
                for (int k = 1; k < 4; k++) rdq[d][k] <= rdq[d][k-1];
            end
            if ((wr_en_v & rd_en_v) != 3'b000) overlap <= overlap + 1;
        end
    end

    always_comb begin
        for (int d = 0; d < 3; d++) rd_data_v[d] = rdq[d][lat_of(d) - 1];
    end

    function automatic logic [15:0] pass1_word(input int i);
        case (i)
            0: return 16'hACE1;  1: return 16'hE270;  2: return 16'h7138;  3: return 16'h389C;
            4: return 16'h1C4E;  5: return 16'h0E27;  6: return 16'hB313;  default: return 16'hED89;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond_met(input int d, input int what, input int n);
        case (what)
            0: return wr_en_v[d];
            1: return rd_en_v[d];
            2: return pass_v[d] == 16'(n);
            default: return done_v[d];
        endcase
    endfunction

    // what: 0 wr_en high, 1 rd_en high, 2 pass_cnt == n, 3 done high
    task automatic wait_for(input int d, input int what, input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (cond_met(d, what, n)) break;
            tick();
        end
        n_checks++;
        if (i == budget) $display("FAIL %s: condition not reached within %0d cycles", name, budget);
        else n_pass++;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++; if (wr_en_v[0] !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", wr_en_v[0]); else n_pass++;
        n_checks++; if (rd_en_v[0] !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", rd_en_v[0]); else n_pass++;
        n_checks++; if (flag_v !== 3'b000) $display("FAIL rst_error_flag: got %b want 000", flag_v); else n_pass++;
        n_checks++; if (err_v[0] !== 16'h0) $display("FAIL rst_err_cnt: got %h want 0000", err_v[0]); else n_pass++;
        n_checks++; if (pass_v[0] !== 16'h0) $display("FAIL rst_pass_cnt: got %h want 0000", pass_v[0]); else n_pass++;
        n_checks++; if (first_v[0] !== 28'h0) $display("FAIL rst_first_err: got %h want 0", first_v[0]); else n_pass++;
        n_checks++; if (done_v !== 3'b000) $display("FAIL rst_done: got %b want 000", done_v); else n_pass++;
    endtask

    task automatic test_loopback();
        rst = 1'b0;
        init_v[0] = 1'b1;
        wait_for(0, 0, 0, 20, "t1_wr_start");
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (wr_en_v[0] !== 1'b1) $display("FAIL t1_wr_en[%0d]: got %b want 1", i, wr_en_v[0]); else n_pass++;
            n_checks++; if (wr_data_v[0] !== pass1_word(i))
                $display("FAIL t1_wr_data[%0d]: got %h want %h", i, wr_data_v[0], pass1_word(i)); else n_pass++;
            tick();
        end
        n_checks++; if (wr_en_v[0] !== 1'b0) $display("FAIL t1_wr_end: got %b want 0", wr_en_v[0]); else n_pass++;
        wait_for(0, 2, 1, 100, "t1_pass1");
        n_checks++; if (err_v[0] !== 16'h0) $display("FAIL t1_err_cnt: got %h want 0000", err_v[0]); else n_pass++;
        n_checks++; if (flag_v[0] !== 1'b0) $display("FAIL t1_error_flag: got %b want 0", flag_v[0]); else n_pass++;
        n_checks++; if (rd_cnt[0] !== 8) $display("FAIL t1_rd_strobes: got %0d want 8", rd_cnt[0]); else n_pass++;
        n_checks++; if (wr_data_v[0] !== 16'hC2C4) $display("FAIL t1_next_seed: got %h want c2c4", wr_data_v[0]); else n_pass++;
    endtask

    task automatic test_error();
        corrupt[0] = 3;
        wait_for(0, 2, 2, 100, "t2_pass2");
        n_checks++; if (flag_v[0] !== 1'b1) $display("FAIL t2_error_flag: got %b want 1", flag_v[0]); else n_pass++;
        n_checks++; if (err_v[0] !== 16'd1) $display("FAIL t2_err_cnt: got %0d want 1", err_v[0]); else n_pass++;
        n_checks++; if (first_v[0] !== 28'd3) $display("FAIL t2_first_err: got %0d want 3", first_v[0]); else n_pass++;
        corrupt[0] = -1;
        wait_for(0, 2, 3, 100, "t2_pass3");
        n_checks++; if (flag_v[0] !== 1'b1) $display("FAIL t2_sticky_flag: got %b want 1", flag_v[0]); else n_pass++;
        n_checks++; if (err_v[0] !== 16'd1) $display("FAIL t2_clean_err_cnt: got %0d want 1", err_v[0]); else n_pass++;
        corrupt[0] = 5;
        wait_for(0, 2, 4, 100, "t2_pass4");
        n_checks++; if (err_v[0] !== 16'd2) $display("FAIL t2_second_err_cnt: got %0d want 2", err_v[0]); else n_pass++;
        n_checks++; if (first_v[0] !== 28'd3) $display("FAIL t2_first_err_kept: got %0d want 3", first_v[0]); else n_pass++;
        corrupt[0] = -1;
    endtask

    task automatic test_init_drop();
        rst = 1'b1; tick(); rst = 1'b0;
        wait_for(0, 2, 1, 100, "t3_pass1");
        n_checks++; if (wr_data_v[0] !== 16'hC2C4) $display("FAIL t3_addr0: got %h want c2c4", wr_data_v[0]); else n_pass++;
        repeat (4) tick();
        n_checks++; if (wr_data_v[0] !== 16'h562C) $display("FAIL t3_addr4: got %h want 562c", wr_data_v[0]); else n_pass++;
        init_v[0] = 1'b0;
        tick();
        n_checks++; if (wr_en_v[0] !== 1'b0) $display("FAIL t3_wr_drop: got %b want 0", wr_en_v[0]); else n_pass++;
        n_checks++; if (pass_v[0] !== 16'd1) $display("FAIL t3_pass_kept: got %0d want 1", pass_v[0]); else n_pass++;
        repeat (3) tick();
        n_checks++; if ({wr_en_v[0], rd_en_v[0]} !== 2'b00) $display("FAIL t3_idle_strobes: got %b want 00", {wr_en_v[0], rd_en_v[0]}); else n_pass++;
        init_v[0] = 1'b1;
        wait_for(0, 0, 0, 10, "t3_restart");
        n_checks++; if (wr_data_v[0] !== 16'hC2C4) $display("FAIL t3_restart_seed: got %h want c2c4", wr_data_v[0]); else n_pass++;
        wait_for(0, 2, 2, 100, "t3_pass2");
        n_checks++; if (err_v[0] !== 16'h0) $display("FAIL t3_err_cnt: got %h want 0000", err_v[0]); else n_pass++;
    endtask

    task automatic test_single_pass();
        init_v[1] = 1'b1;
        wait_for(1, 0, 0, 20, "t4_wr_start");
        n_checks++; if (wr_data_v[1] !== 16'h0001) $display("FAIL t4_zero_seed: got %h want 0001", wr_data_v[1]); else n_pass++;
        tick();
        n_checks++; if (wr_data_v[1] !== 16'hB400) $display("FAIL t4_word1: got %h want b400", wr_data_v[1]); else n_pass++;
        wait_for(1, 3, 0, 100, "t4_done");
        n_checks++; if (wr_cnt[1] !== 4) $display("FAIL t4_wr_strobes: got %0d want 4", wr_cnt[1]); else n_pass++;
        n_checks++; if (rd_cnt[1] !== 4) $display("FAIL t4_rd_strobes: got %0d want 4", rd_cnt[1]); else n_pass++;
        n_checks++; if (pass_v[1] !== 16'd1) $display("FAIL t4_pass_cnt: got %0d want 1", pass_v[1]); else n_pass++;
        n_checks++; if (err_v[1] !== 16'd0) $display("FAIL t4_err_cnt: got %0d want 0", err_v[1]); else n_pass++;
        repeat (20) tick();
        n_checks++; if (wr_cnt[1] + rd_cnt[1] !== 8) $display("FAIL t4_no_more_strobes: got %0d want 8", wr_cnt[1] + rd_cnt[1]); else n_pass++;
        n_checks++; if (done_v[1] !== 1'b1) $display("FAIL t4_done_held: got %b want 1", done_v[1]); else n_pass++;
    endtask

    task automatic test_latency();
        init_v[2] = 1'b1;
        wait_for(2, 2, 3, 300, "t5_pass3");
        n_checks++; if (err_v[2] !== 16'd0) $display("FAIL t5_err_cnt: got %0d want 0", err_v[2]); else n_pass++;
        n_checks++; if (flag_v[2] !== 1'b0) $display("FAIL t5_error_flag: got %b want 0", flag_v[2]); else n_pass++;
        n_checks++; if (rd_cnt[2] !== 24) $display("FAIL t5_rd_strobes: got %0d want 24", rd_cnt[2]); else n_pass++;
        corrupt[2] = 7;
        wait_for(2, 2, 4, 100, "t5_pass4");
        n_checks++; if (err_v[2] !== 16'd1) $display("FAIL t5_last_word_err: got %0d want 1", err_v[2]); else n_pass++;
        n_checks++; if (first_v[2] !== 28'd7) $display("FAIL t5_first_err: got %0d want 7", first_v[2]); else n_pass++;
        corrupt[2] = -1;
        n_checks++; if (overlap !== 0) $display("FAIL back_to_back_overlap: got %0d want 0", overlap); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        init_v[2:1] = 2'b00;
        wait_for(0, 1, 0, 100, "t6_read");
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({wr_en_v[0], rd_en_v[0]} !== 2'b00) $display("FAIL t6_strobes: got %b want 00", {wr_en_v[0], rd_en_v[0]}); else n_pass++;
        n_checks++; if (pass_v[0] !== 16'd0) $display("FAIL t6_pass_cnt: got %0d want 0", pass_v[0]); else n_pass++;
        @(negedge clk) rst = 1'b0;
        wait_for(0, 0, 0, 20, "t6_restart");
        n_checks++; if (wr_data_v[0] !== 16'hACE1) $display("FAIL t6_seed: got %h want ace1", wr_data_v[0]); else n_pass++;
        wait_for(0, 2, 1, 100, "t6_pass1");
        n_checks++; if (err_v[0] !== 16'd0) $display("FAIL t6_err_cnt: got %0d want 0", err_v[0]); else n_pass++;
        n_checks++; if (wr_data_v[0] !== 16'hC2C4) $display("FAIL t6_next_seed: got %h want c2c4", wr_data_v[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_error();
        test_init_drop();
        test_single_pass();
        test_latency();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
